// File: rtl/muldiv_ctrl.sv
// Iterative MIPS mul/div sequencer that owns HI/LO. Each op takes WIDTH+1 edges from start to result.
// While busy, start and MTHI/MTLO are ignored, so upstream holds the op until busy drops.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic               is_div, neg_a, neg_b, div_zero;
    logic [WIDTH-1:0]   opd;    // |multiplicand| or |divisor|
    logic [WIDTH-1:0]   acc;    // product high half or partial remainder
    logic [WIDTH-1:0]   shf;    // multiplier bits or quotient bits
    logic               last;

    logic               in_neg_a, in_neg_b;
    logic [WIDTH-1:0]   abs_a, abs_b;

    logic [WIDTH:0]     mul_sum, div_shl, div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   nxt_acc, nxt_shf;
    logic [2*WIDTH-1:0] prod, prod_res;
    logic [WIDTH-1:0]   quo_res, rem_res;

    assign last = (cnt == CW'(WIDTH - 1));

    // Signed ops iterate on magnitudes; op[0]=0 marks the signed variants.
    assign in_neg_a = ~op[0] & a[WIDTH-1];
    assign in_neg_b = ~op[0] & b[WIDTH-1];
    assign abs_a    = in_neg_a ? -a : a;
    assign abs_b    = in_neg_b ? -b : b;

    always_comb begin
        mul_sum  = {1'b0, acc} + (shf[0] ? {1'b0, opd} : '0);
        div_shl  = {acc, shf[WIDTH-1]};
        div_diff = div_shl - {1'b0, opd};
        div_ok   = ~div_diff[WIDTH];
        if (is_div) begin
            nxt_acc = div_ok ? div_diff[WIDTH-1:0] : div_shl[WIDTH-1:0];
            nxt_shf = {shf[WIDTH-2:0], div_ok};
        end else begin
            nxt_acc = mul_sum[WIDTH:1];
            nxt_shf = {mul_sum[0], shf[WIDTH-1:1]};
        end
        prod     = {nxt_acc, nxt_shf};
        prod_res = (neg_a ^ neg_b) ? -prod : prod;
        // Divide by zero leaves rem=|a|, so restoring its sign yields hi=a.
        quo_res  = div_zero ? '1 : ((neg_a ^ neg_b) ? -nxt_shf : nxt_shf);
        rem_res  = neg_a ? -nxt_acc : nxt_acc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            opd      <= '0;
            acc      <= '0;
            shf      <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    is_div   <= op[1];
                    neg_a    <= in_neg_a;
                    neg_b    <= in_neg_b;
                    div_zero <= (b == '0);
                    opd      <= abs_b;
                    acc      <= '0;
                    shf      <= abs_a;
                    cnt      <= '0;
                end else begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                end
            end else begin
                acc <= nxt_acc;
                shf <= nxt_shf;
                cnt <= cnt + CW'(1);
                if (last) begin
                    cnt  <= '0;
                    done <= 1'b1;
                    if (is_div) begin
                        hi <= rem_res;
                        lo <= quo_res;
                    end else begin
                        hi <= prod_res[2*WIDTH-1:WIDTH];
                        lo <= prod_res[WIDTH-1:0];
                    end
                end
            end
        end
    end

endmodule
